// File: rtl/eth_rx_seq_window_pkg.sv
// Shared libeth types for the RX sequence window filter: pipe slot and ring header
// layouts, packet type codes, and the windowed sequence classifier.
package eth_rx_seq_window_pkg;

   localparam int SEQ_W = 16;

   typedef enum logic [1:0] {
      rx_none  = 2'd0,
      rx_start = 2'd1,
      rx_data  = 2'd2,
      rx_end   = 2'd3
   } eth_rx_stype_type;

   typedef struct packed {
      eth_rx_stype_type stype;
      logic [31:0]      msg;
   } eth_rx_pipe_data_type;

   typedef struct packed {
      logic [SEQ_W-1:0] seqnum;
      logic [7:0]       pid;
      logic [7:0]       ptype;
   } eth_ring_header_type;

   localparam logic [7:0] BCASTPID       = 8'hFF;
   localparam logic [7:0] ackPacketType  = 8'hFE;
   localparam logic [7:0] nackPacketType = 8'hFF;

   typedef enum logic [1:0] {
      seq_inorder,
      seq_ahead,
      seq_retx,
      seq_stale
   } eth_seq_class_type;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FWD,
      ST_DROP
   } eth_seq_state_type;

   // Ahead covers diff 1..window-1, retransmit covers the last `window` values behind expected.
   function automatic eth_seq_class_type seqClassify(input logic [SEQ_W-1:0] seqnum,
                                                     input logic [SEQ_W-1:0] expected,
                                                     input logic [SEQ_W:0]   window);
      logic [SEQ_W-1:0] diff;
      logic [SEQ_W:0]   behind_lim;
      diff       = seqnum - expected;
      behind_lim = 17'h10000 - window;
      if (diff == '0)
         return seq_inorder;
      else if ({1'b0, diff} < window)
         return seq_ahead;
      else if ({1'b0, diff} >= behind_lim)
         return seq_retx;
      else
         return seq_stale;
   endfunction

endpackage

// File: rtl/eth_rx_seq_window_ack.sv
// ACK/NACK event FIFO: pushes while full are refused (full is judged before a same-cycle pop),
// head is presented with valid and popped on valid & ready.
module eth_ack_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic             valid,
   input  logic             ready,
   output logic [WIDTH-1:0] data
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign valid   = (wr_ptr != rd_ptr);
   assign data    = valid ? mem[rd_ptr[PW-1:0]] : '0;
   assign do_push = push && !full;
   assign do_pop  = valid && ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + (PW+1)'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/eth_rx_seq_window.sv
// Windowed per-pipeline RX sequence filter: forwards in-order frames with one cycle of
// latency, drops retransmits / out-of-window / foreign frames and queues ACK/NACK events.
module eth_rx_seq_window
   import eth_rx_seq_window_pkg::*;
#(
   parameter int NPIPE      = 4,
   parameter int WINDOW     = 8,
   parameter int ACKQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [33:0] rx_in,
   output logic [33:0] rx_out,
   output logic        ack_valid,
   input  logic        ack_ready,
   output logic [31:0] ack_data,
   input  logic        seq_clr,
   input  logic [7:0]  seq_clr_pid,
   output logic [15:0] drop_cnt,
   output logic [15:0] ackovf_cnt
);

   localparam logic [SEQ_W:0] WIN     = (SEQ_W+1)'(WINDOW);
   localparam logic [7:0]     NPIPE_L = 8'(NPIPE);

   eth_seq_state_type    state, state_next;
   eth_rx_pipe_data_type rx_in_s;
   eth_rx_pipe_data_type rx_out_q, rx_out_next;
   eth_ring_header_type  enq_data;
   eth_seq_class_type    cls;

   logic [SEQ_W-1:0] expected [NPIPE];
   logic [SEQ_W-1:0] exp_cur;
   logic [SEQ_W-1:0] hdr_seq;
   logic [7:0]       hdr_pid;
   logic             pid_known;
   logic [7:0]       cur_pid;
   logic [SEQ_W-1:0] cur_seq;
   logic             cur_bcast;
   logic             latch_hdr;
   logic             enq;
   logic             commit;
   logic             drop_inc;
   logic             ack_full;

   assign rx_in_s   = rx_in;
   assign rx_out    = rx_out_q;
   assign hdr_seq   = rx_in_s.msg[31:16];
   assign hdr_pid   = rx_in_s.msg[15:8];
   assign pid_known = (hdr_pid < NPIPE_L);
   assign cls       = seqClassify(hdr_seq, exp_cur, WIN);

   always_comb begin
      exp_cur = '0;
      for (int i = 0; i < NPIPE; i++)
         if (hdr_pid == 8'(i))
            exp_cur = expected[i];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // A new rx_start always wins over whatever frame is in flight; that frame is silently abandoned.
   always_comb begin
      state_next  = state;
      rx_out_next = '{stype: rx_none, msg: '0};
      enq         = 1'b0;
      enq_data    = '0;
      commit      = 1'b0;
      drop_inc    = 1'b0;
      latch_hdr   = 1'b0;
      if (rx_in_s.stype == rx_start) begin
         latch_hdr = 1'b1;
         if (hdr_pid == BCASTPID) begin
            state_next  = ST_FWD;
            rx_out_next = rx_in_s;
         end else if (!pid_known) begin
            state_next = ST_DROP;
            drop_inc   = 1'b1;
         end else begin
            case (cls)
               seq_inorder: begin
                  state_next  = ST_FWD;
                  rx_out_next = rx_in_s;
               end
               seq_ahead: begin
                  state_next = ST_DROP;
                  drop_inc   = 1'b1;
                  enq        = 1'b1;
                  enq_data   = '{seqnum: exp_cur, pid: hdr_pid, ptype: nackPacketType};
               end
               seq_retx: begin
                  state_next = ST_DROP;
                  drop_inc   = 1'b1;
                  enq        = 1'b1;
                  enq_data   = '{seqnum: hdr_seq, pid: hdr_pid, ptype: ackPacketType};
               end
               default: begin
                  state_next = ST_DROP;
                  drop_inc   = 1'b1;
               end
            endcase
         end
      end else begin
         case (state)
            ST_FWD: begin
               rx_out_next = rx_in_s;
               if (rx_in_s.stype == rx_end) begin
                  state_next = ST_IDLE;
                  if (rx_in_s.msg[0] && !cur_bcast) begin
                     commit   = 1'b1;
                     enq      = 1'b1;
                     enq_data = '{seqnum: cur_seq, pid: cur_pid, ptype: ackPacketType};
                  end
               end
            end
            ST_DROP: begin
               if (rx_in_s.stype == rx_end)
                  state_next = ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // A clear on the same pid overrides a commit landing on the same edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_out_q   <= '{stype: rx_none, msg: '0};
         cur_pid    <= '0;
         cur_seq    <= '0;
         cur_bcast  <= 1'b0;
         drop_cnt   <= '0;
         ackovf_cnt <= '0;
         for (int i = 0; i < NPIPE; i++)
            expected[i] <= '0;
      end else begin
         rx_out_q <= rx_out_next;
         if (latch_hdr) begin
            cur_pid   <= hdr_pid;
            cur_seq   <= hdr_seq;
            cur_bcast <= (hdr_pid == BCASTPID);
         end
         if (drop_inc && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
         if (enq && ack_full && ackovf_cnt != 16'hFFFF)
            ackovf_cnt <= ackovf_cnt + 16'd1;
         for (int i = 0; i < NPIPE; i++) begin
            if (seq_clr && seq_clr_pid == 8'(i))
               expected[i] <= '0;
            else if (commit && cur_pid == 8'(i))
               expected[i] <= cur_seq + 16'd1;
         end
      end
   end

   eth_ack_fifo #(
      .DEPTH (ACKQ_DEPTH),
      .WIDTH (32)
   ) u_ack_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (enq),
      .push_data (enq_data),
      .full      (ack_full),
      .valid     (ack_valid),
      .ready     (ack_ready),
      .data      (ack_data)
   );

endmodule

// File: tb/tb_eth_rx_seq_window.sv
// Self-checking bench for eth_rx_seq_window: a vector table, directed corner sequences and
// a randomized phase, all compared against a frame-level reference model.
module tb_eth_rx_seq_window;

   localparam int NPIPE      = 4;
   localparam int WINDOW     = 8;
   localparam int ACKQ_DEPTH = 4;

   localparam logic [1:0] S_NONE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_END   = 2'd3;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [33:0] rx_in = '0;
   logic [33:0] rx_out;
   logic        ack_valid;
   logic        ack_ready = 1'b0;
   logic [31:0] ack_data;
   logic        seq_clr = 1'b0;
   logic [7:0]  seq_clr_pid = '0;
   logic [15:0] drop_cnt;
   logic [15:0] ackovf_cnt;

   always #5 clk = ~clk;

   eth_rx_seq_window #(
      .NPIPE      (NPIPE),
      .WINDOW     (WINDOW),
      .ACKQ_DEPTH (ACKQ_DEPTH)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .rx_in       (rx_in),
      .rx_out      (rx_out),
      .ack_valid   (ack_valid),
      .ack_ready   (ack_ready),
      .ack_data    (ack_data),
      .seq_clr     (seq_clr),
      .seq_clr_pid (seq_clr_pid),
      .drop_cnt    (drop_cnt),
      .ackovf_cnt  (ackovf_cnt)
   );

   int    tests = 0;
   int    fails = 0;
   string cur_test = "reset";

   // Reference model: per-pid expected numbers, an event queue, and a frame mode
   // (0 idle, 1 accepted, 2 accepted broadcast, 3 discarding).
   int          m_exp [NPIPE];
   logic [31:0] m_q [$];
   int          m_drop;
   int          m_ovf;
   int          m_mode;
   int          m_pid;
   int          m_seq;
   logic [33:0] m_out;

   function automatic logic [31:0] hdr(input int seq, input int pid);
      return {16'(seq), 8'(pid), 8'h01};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s/%s: got %0h required %0h", cur_test, name, got, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < NPIPE; i++)
         m_exp[i] = 0;
      m_q.delete();
      m_drop = 0;
      m_ovf  = 0;
      m_mode = 0;
      m_pid  = 0;
      m_seq  = 0;
      m_out  = '0;
   endtask

   task automatic modelStep(input logic [33:0] rin, input logic rdy, input logic clr,
                            input logic [7:0] clrpid);
      int          qn;
      bit          enq;
      logic [31:0] ev;
      int          diff;
      int          pid;
      int          seq;
      qn    = m_q.size();
      enq   = 0;
      ev    = '0;
      m_out = '0;
      if (rin[33:32] == S_START) begin
         seq   = int'(rin[31:16]);
         pid   = int'(rin[15:8]);
         m_pid = pid;
         m_seq = seq;
         if (pid == 255) begin
            m_mode = 2;
            m_out  = rin;
         end else if (pid >= NPIPE) begin
            m_mode = 3;
            m_drop++;
         end else begin
            diff = (seq - m_exp[pid] + 65536) % 65536;
            if (diff == 0) begin
               m_mode = 1;
               m_out  = rin;
            end else begin
               m_mode = 3;
               m_drop++;
               if (diff < WINDOW) begin
                  enq = 1;
                  ev  = {16'(m_exp[pid]), 8'(pid), 8'hFF};
               end else if (diff >= 65536 - WINDOW) begin
                  enq = 1;
                  ev  = {16'(seq), 8'(pid), 8'hFE};
               end
            end
         end
      end else if (m_mode == 1 || m_mode == 2) begin
         m_out = rin;
         if (rin[33:32] == S_END) begin
            if (rin[0] && m_mode == 1) begin
               m_exp[m_pid] = (m_seq + 1) % 65536;
               enq = 1;
               ev  = {16'(m_seq), 8'(m_pid), 8'hFE};
            end
            m_mode = 0;
         end
      end else if (m_mode == 3 && rin[33:32] == S_END) begin
         m_mode = 0;
      end
      if (clr && int'(clrpid) < NPIPE)
         m_exp[int'(clrpid)] = 0;
      if (qn > 0 && rdy)
         void'(m_q.pop_front());
      if (enq) begin
         if (qn < ACKQ_DEPTH)
            m_q.push_back(ev);
         else
            m_ovf++;
      end
      if (m_drop > 65535) m_drop = 65535;
      if (m_ovf > 65535) m_ovf = 65535;
   endtask

   task automatic checkOutput();
      logic [31:0] head;
      head = (m_q.size() > 0) ? m_q[0] : 32'h0;
      check("rx_out", 64'(rx_out), 64'(m_out));
      check("ack_valid", 64'(ack_valid), 64'(m_q.size() > 0));
      check("ack_data", 64'(ack_data), 64'(head));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      check("ackovf_cnt", 64'(ackovf_cnt), 64'(m_ovf));
   endtask

   task automatic applyStimulus(input logic [1:0] st, input logic [31:0] msg, input logic rdy,
                                input logic clr = 1'b0, input logic [7:0] clrpid = 8'h0);
      rx_in       = {st, msg};
      ack_ready   = rdy;
      seq_clr     = clr;
      seq_clr_pid = clrpid;
      modelStep({st, msg}, rdy, clr, clrpid);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic sendFrame(input int pid, input int seq, input logic good, input logic rdy);
      applyStimulus(S_START, hdr(seq, pid), rdy);
      applyStimulus(S_DATA, 32'hD00D_0000 + 32'(seq), rdy);
      applyStimulus(S_END, {31'h0, good}, rdy);
   endtask

   task automatic doReset();
      rstn        = 1'b0;
      rx_in       = '0;
      ack_ready   = 1'b0;
      seq_clr     = 1'b0;
      seq_clr_pid = '0;
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  st;
      logic [31:0] msg;
      logic        rdy;
      logic [33:0] exp_out;
      logic        exp_valid;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [12];

   initial begin
      #1000000;
      fails++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      vecs[0]  = '{S_START, hdr(0, 2),     1'b0, {S_START, hdr(0, 2)},     1'b0, 32'h0};
      vecs[1]  = '{S_DATA,  32'hAAAA0000,  1'b0, {S_DATA, 32'hAAAA0000},   1'b0, 32'h0};
      vecs[2]  = '{S_END,   32'h1,         1'b0, {S_END, 32'h1},           1'b1, 32'h000002FE};
      vecs[3]  = '{S_START, hdr(1, 2),     1'b0, {S_START, hdr(1, 2)},     1'b1, 32'h000002FE};
      vecs[4]  = '{S_END,   32'h1,         1'b0, {S_END, 32'h1},           1'b1, 32'h000002FE};
      vecs[5]  = '{S_START, hdr(2, 2),     1'b0, {S_START, hdr(2, 2)},     1'b1, 32'h000002FE};
      vecs[6]  = '{S_END,   32'h1,         1'b0, {S_END, 32'h1},           1'b1, 32'h000002FE};
      vecs[7]  = '{S_NONE,  32'h0,         1'b1, 34'h0,                    1'b1, 32'h000102FE};
      vecs[8]  = '{S_NONE,  32'h0,         1'b1, 34'h0,                    1'b1, 32'h000202FE};
      vecs[9]  = '{S_NONE,  32'h0,         1'b1, 34'h0,                    1'b0, 32'h0};
      vecs[10] = '{S_START, hdr(3, 2),     1'b0, {S_START, hdr(3, 2)},     1'b0, 32'h0};
      vecs[11] = '{S_END,   32'h0,         1'b0, {S_END, 32'h0},           1'b0, 32'h0};

      doReset();
      check("reset.rx_out", 64'(rx_out), 64'h0);
      check("reset.ack_valid", 64'(ack_valid), 64'h0);
      check("reset.ack_data", 64'(ack_data), 64'h0);
      check("reset.drop_cnt", 64'(drop_cnt), 64'h0);
      check("reset.ackovf_cnt", 64'(ackovf_cnt), 64'h0);

      cur_test = "inorder_table";
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].st, vecs[i].msg, vecs[i].rdy);
         check($sformatf("row%0d.rx_out", i), 64'(rx_out), 64'(vecs[i].exp_out));
         check($sformatf("row%0d.ack_valid", i), 64'(ack_valid), 64'(vecs[i].exp_valid));
         check($sformatf("row%0d.ack_data", i), 64'(ack_data), 64'(vecs[i].exp_data));
         check($sformatf("row%0d.drop_cnt", i), 64'(drop_cnt), 64'h0);
      end

      cur_test = "retransmit";
      doReset();
      for (int s = 0; s <= 5; s++)
         sendFrame(1, s, 1'b1, 1'b1);
      applyStimulus(S_NONE, 32'h0, 1'b1);
      applyStimulus(S_START, hdr(5, 1), 1'b0);
      check("rx_out", 64'(rx_out[33:32]), 64'(S_NONE));
      check("ack_data", 64'(ack_data), 64'h000501FE);
      check("drop_cnt", 64'(drop_cnt), 64'd1);
      applyStimulus(S_DATA, 32'h1234, 1'b0);
      applyStimulus(S_END, 32'h1, 1'b0);
      check("end_rx_out", 64'(rx_out), 64'h0);
      applyStimulus(S_START, hdr(6, 1), 1'b1);
      check("next_fwd", 64'(rx_out), 64'({S_START, hdr(6, 1)}));
      applyStimulus(S_END, 32'h1, 1'b1);

      cur_test = "ahead";
      doReset();
      for (int s = 0; s < 10; s++)
         sendFrame(0, s, 1'b1, 1'b1);
      applyStimulus(S_NONE, 32'h0, 1'b1);
      applyStimulus(S_START, hdr(13, 0), 1'b0);
      check("nack_data", 64'(ack_data), 64'h000A00FF);
      check("drop_cnt", 64'(drop_cnt), 64'd1);
      applyStimulus(S_END, 32'h1, 1'b1);
      applyStimulus(S_START, hdr(18, 0), 1'b0);
      check("diff8_no_ack", 64'(ack_valid), 64'h0);
      check("diff8_drop", 64'(drop_cnt), 64'd2);
      applyStimulus(S_END, 32'h1, 1'b0);
      applyStimulus(S_START, hdr(17, 0), 1'b0);
      check("diff7_nack", 64'(ack_data), 64'h000A00FF);
      applyStimulus(S_END, 32'h1, 1'b1);
      sendFrame(0, 10, 1'b1, 1'b1);

      cur_test = "wrap_bad";
      doReset();
      applyStimulus(S_START, hdr(16'hFFFF, 3), 1'b0);
      check("retx_wrap", 64'(ack_data), 64'hFFFF03FE);
      applyStimulus(S_END, 32'h1, 1'b1);
      applyStimulus(S_START, hdr(16'hFFF8, 3), 1'b0);
      check("retx_edge", 64'(ack_data), 64'hFFF803FE);
      applyStimulus(S_END, 32'h1, 1'b1);
      applyStimulus(S_START, hdr(16'hFFF7, 3), 1'b0);
      check("stale_no_ack", 64'(ack_valid), 64'h0);
      check("stale_drop", 64'(drop_cnt), 64'd3);
      applyStimulus(S_END, 32'h1, 1'b0);
      applyStimulus(S_START, hdr(0, 3), 1'b0);
      applyStimulus(S_END, 32'h0, 1'b0);
      check("bad_end_fwd", 64'(rx_out), 64'({S_END, 32'h0}));
      check("bad_no_ack", 64'(ack_valid), 64'h0);
      applyStimulus(S_START, hdr(0, 3), 1'b0);
      check("still_zero", 64'(rx_out), 64'({S_START, hdr(0, 3)}));
      applyStimulus(S_END, 32'h1, 1'b0);

      cur_test = "overflow";
      doReset();
      for (int s = 0; s < 5; s++)
         sendFrame(1, s, 1'b1, 1'b0);
      check("ackovf_cnt", 64'(ackovf_cnt), 64'd1);
      applyStimulus(S_START, hdr(5, 1), 1'b0);
      check("advanced5", 64'(rx_out), 64'({S_START, hdr(5, 1)}));
      applyStimulus(S_END, 32'h0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(S_NONE, 32'h0, 1'b1);
         check($sformatf("drain%0d", k), 64'(ack_data),
               (k < 4) ? 64'({16'(k), 16'h01FE}) : 64'h0);
      end

      cur_test = "abort";
      doReset();
      applyStimulus(S_START, hdr(0, 2), 1'b0);
      applyStimulus(S_DATA, 32'h5555, 1'b0);
      applyStimulus(S_START, hdr(0, 2), 1'b0);
      check("restart_fwd", 64'(rx_out), 64'({S_START, hdr(0, 2)}));
      check("no_commit_ack", 64'(ack_valid), 64'h0);
      applyStimulus(S_DATA, 32'h6666, 1'b0);
      applyStimulus(S_END, 32'h1, 1'b0);
      check("ack", 64'(ack_data), 64'h000002FE);
      applyStimulus(S_START, hdr(1, 2), 1'b0);
      applyStimulus(S_DATA, 32'h7777, 1'b0);
      rstn = 1'b0;
      #1;
      modelReset();
      checkOutput();
      check("async_rx_out", 64'(rx_out), 64'h0);
      check("async_q_empty", 64'(ack_valid), 64'h0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(S_START, hdr(0, 2), 1'b0);
      check("exp_cleared", 64'(rx_out), 64'({S_START, hdr(0, 2)}));
      applyStimulus(S_END, 32'h1, 1'b1);

      cur_test = "foreign_bcast";
      doReset();
      applyStimulus(S_START, hdr(0, 200), 1'b0);
      check("foreign_drop", 64'(drop_cnt), 64'd1);
      check("foreign_rx", 64'(rx_out), 64'h0);
      applyStimulus(S_END, 32'h1, 1'b0);
      applyStimulus(S_START, hdr(5, 255), 1'b0);
      check("bcast_fwd", 64'(rx_out), 64'({S_START, hdr(5, 255)}));
      applyStimulus(S_END, 32'h1, 1'b0);
      check("bcast_no_ack", 64'(ack_valid), 64'h0);

      cur_test = "seq_clr";
      doReset();
      applyStimulus(S_START, hdr(0, 0), 1'b0);
      applyStimulus(S_END, 32'h1, 1'b0, 1'b1, 8'd0);
      check("ack_despite_clr", 64'(ack_data), 64'h000000FE);
      applyStimulus(S_START, hdr(0, 0), 1'b0, 1'b1, 8'd9);
      check("clr_beats_commit", 64'(rx_out), 64'({S_START, hdr(0, 0)}));
      applyStimulus(S_END, 32'h1, 1'b1);

      cur_test = "random";
      doReset();
      for (int n = 0; n < 1500; n++) begin
         int          r;
         int          pid;
         int          seq;
         logic [1:0]  st;
         logic [31:0] msg;
         r   = $urandom_range(0, 9);
         st  = (r < 2) ? S_NONE : (r < 4) ? S_START : (r < 7) ? S_DATA : S_END;
         msg = $urandom();
         if (st == S_START) begin
            r = $urandom_range(0, 7);
            pid = (r < 4) ? r : (r == 4) ? 5 : (r == 5) ? 200 : (r == 6) ? 255
                : $urandom_range(0, 3);
            if (pid < NPIPE && $urandom_range(0, 7) != 0)
               seq = (m_exp[pid] + $urandom_range(0, 24) - 12 + 65536) % 65536;
            else
               seq = $urandom_range(0, 65535);
            msg = {16'(seq), 8'(pid), 8'($urandom_range(0, 255))};
         end
         applyStimulus(st, msg, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 29) == 0, 8'($urandom_range(0, 5)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/eth_rx_seq_window.md
Name: eth_rx_seq_window

Overview:
- Windowed per-pipeline sequence filter on the RX pipe stream. Sits between the MAC RX side and the pipeline dispatchers.
- Generalises single-outstanding (cwnd == 1) retransmit detection to a configurable window and NPIPE pipelines.
- Forwards in-order frames and drops retransmits, out-of-window and foreign frames.
- Queues ACK/NACK events for the TX ring builder.

Parameters:
- NPIPE, 4, number of pipelines tracked (pids 0..NPIPE-1), 1..64
- WINDOW, 8, sequence window size, 1..256; WINDOW=1 reproduces cwnd==1 behaviour
- ACKQ_DEPTH, 4, ACK event queue entries, power of 2, >=2

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_in  in  34  eth_rx_pipe_data_type slot from MAC
- rx_out  out  34  eth_rx_pipe_data_type slot to dispatchers
- ack_valid  out  1  ACK queue head valid
- ack_ready  in  1  consumer pops head when ack_valid & ack_ready
- ack_data  out  32  eth_ring_header_type {seqnum, pid, ptype}
- seq_clr  in  1  clear expected seq of seq_clr_pid to 0
- seq_clr_pid  in  8  pipeline id for seq_clr
- drop_cnt  out  16  frames dropped, saturating
- ackovf_cnt  out  16  ACK events lost to full queue, saturating

Behaviour:
- Reset: rx_out.stype=rx_none, msg=0; all expected[]=0; queue empty; ack_valid=0; ack_data=0; counters=0; FSM=IDLE.
- FSM states: IDLE, FWD (accepted frame), DROP (discarding frame).
- Classification on rx_start (any state):
  - Uses header from rx_in.msg and expected[pid]; diff = (seqnum - expected[pid]) mod 2^16.
  - pid==BCASTPID: FWD, no seq check, no ACK.
  - pid>=NPIPE and not BCASTPID: DROP, drop_cnt++.
  - diff==0: FWD; latch pid and seqnum.
  - 1<=diff<=WINDOW-1: DROP; enqueue {expected[pid], pid, nackPacketType}; drop_cnt++.
  - diff >= 2^16-WINDOW (behind, inside window): retransmit; DROP; enqueue {seqnum, pid, ackPacketType}; drop_cnt++.
  - Any other diff: DROP, drop_cnt++, no ACK.
- rx_start arriving in FWD or DROP: previous frame is treated as bad (no commit, no ACK, no extra drop count). The new frame is classified normally. rx_out emits the new rx_start.
- Forwarding:
  - In FWD, and for the accepted rx_start itself: rx_out = rx_in registered, exactly 1 cycle latency.
  - Otherwise rx_out.stype = rx_none.
  - rx_none input in FWD: forwards rx_none, state unchanged.
- rx_end in FWD:
  - Forwarded; FSM goes to IDLE.
  - If msg.data[0]==1 (good) and pid!=BCASTPID: expected[pid] <= seqnum+1 (16-bit wrap, 0xFFFF->0x0000); enqueue {seqnum, pid, ackPacketType}.
  - If bad: no commit, no ACK.
- rx_end in DROP: go to IDLE, nothing emitted.
- rx_data or rx_end in IDLE: ignored, rx_out rx_none.
- ACK queue:
  - FIFO, order preserved; ack_data valid while ack_valid; pop on ack_valid & ack_ready.
  - An event enqueued at cycle N is visible no earlier than cycle N+1.
  - Enqueue when full (evaluated before a same-cycle pop): event discarded, ackovf_cnt++. An expected[] commit still occurs; the sender's retransmit is later re-ACKed.
- seq_clr: expected[seq_clr_pid] <= 0 next edge. Ignored if pid>=NPIPE. Beats a same-cycle commit to the same pid. Classification in the same cycle uses the pre-clear value.
- Counters saturate at 0xFFFF.
- Async reset mid-frame aborts everything immediately: no ACK, no commit.

Decomposition:
- Add to libeth:
  - enum eth_seq_class_type {seq_inorder, seq_ahead, seq_retx, seq_stale}.
  - Function seqClassify(seqnum, expected, window), generalising isRetransmit.
  - Constant SEQ_W=16.
- Reuse from libeth: eth_rx_pipe_data_type, eth_ring_header_type, BCASTPID, ackPacketType, nackPacketType.
- Sub-module eth_ack_fifo (ACKQ_DEPTH x 32, valid/ready pop, full flag).
- expected[] is a NPIPE x 16 register array in the top module.

Test Plan:
- In-order: pid 2, seqs 0,1,2, good ends -> all slots forwarded at +1 cycle; ACKs {0,2,FE},{1,2,FE},{2,2,FE}; expected[2]=3.
- Retransmit: after commit of seq 5 on pid 1, resend seq 5 -> rx_out all rx_none; ACK {5,1,FE}; drop_cnt=1; expected[1] stays 6.
- Ahead in window: expected[0]=10, seq 13, WINDOW=8 -> dropped; NACK {10,0,FF}. Same test with seq 18 (diff 8) -> dropped, no ACK.
- Wrap and bad frame: expected[3]=0xFFFF, good seq 0xFFFF -> expected=0x0000. Next frame seq 0 with end data[0]=0 -> forwarded but no ACK; expected stays 0.
- Queue overflow: ack_ready=0, ACKQ_DEPTH=4, 5 good in-order frames -> 4 queued, ackovf_cnt=1, expected advanced by 5. Raising ack_ready drains 4 in order.
- Abort and reset: rx_start, data, then a new rx_start without end -> first frame not committed. Then rstn low mid-frame -> rx_out rx_none, queue empty, expected[]=0. Plus foreign pid 200 dropped; BCASTPID forwarded with no ACK.
